reg_file_8x32: RTL and testbench

- 8-entry x 32-bit general-purpose register file.
- One synchronous write port and two independent combinational read ports (A and B).
- Serves as the operand store of the datapath: two source operands are read per cycle and one result is written back.

---
 rtl/reg_file_8x32_pkg.sv | 21 ++
 rtl/reg_file_8x32_rd_mux.sv | 15 +
 rtl/reg_file_8x32.sv | 52 +++++
 tb/tb_reg_file_8x32.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_8x32_pkg.sv
// Shared constants and types for the 8 x 32-bit register file.
package reg_file_8x32_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_word_t;

    // One-hot write select: a single bit set at addr when en is high, all zero otherwise.
    function automatic logic [DEPTH-1:0] addr_onehot(input logic [ADDR_W-1:0] addr,
                                                     input logic              en);
        logic [DEPTH-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/reg_file_8x32_rd_mux.sv
// Combinational read multiplexer: selects one register word by address.
module regfile_rd_mux
    import reg_file_8x32_pkg::*;
(
    input  reg_word_t [DEPTH-1:0]  regs,
    input  logic      [ADDR_W-1:0] addr,
    output reg_word_t              q
);

    // Zero-latency read: the output follows the address within the same cycle.
    always_comb begin
        q = regs[addr];
    end

endmodule

// File: rtl/reg_file_8x32.sv
// 8 x 32-bit register file: one synchronous write port, two combinational read ports.
// There is no write-to-read bypass: a read of the register being written shows the
// old value until the rising edge, and the new value after it.
module reg_file_8x32
    import reg_file_8x32_pkg::*;
(
    input  logic              clk,
    input  logic              cr,
    input  logic              WE,
    input  logic [DATA_W-1:0] Di,
    input  logic [ADDR_W-1:0] Addr_W,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB
);

    logic      [DEPTH-1:0] wr_sel;
    reg_word_t [DEPTH-1:0] regs;

    assign wr_sel = addr_onehot(Addr_W, WE);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            reg_word_t word_reg;

            // Each register clears asynchronously on cr low (overriding any write) and loads Di when selected.
            always_ff @(posedge clk or negedge cr) begin
                if (!cr) begin
                    word_reg <= '0;
                end else if (wr_sel[gi]) begin
                    word_reg <= Di;
                end
            end

            assign regs[gi] = word_reg;
        end
    endgenerate

    regfile_rd_mux u_rd_mux_a (
        .regs (regs),
        .addr (Addr_A),
        .q    (QA)
    );

    regfile_rd_mux u_rd_mux_b (
        .regs (regs),
        .addr (Addr_B),
        .q    (QB)
    );

endmodule

// File: tb/tb_reg_file_8x32.sv
// Self-checking bench for reg_file_8x32: scoreboard of expected read values.
module tb_reg_file_8x32;

    logic        clk;
    logic        cr;
    logic        WE;
    logic [31:0] Di;
    logic [2:0]  Addr_W;
    logic [2:0]  Addr_A;
    logic [2:0]  Addr_B;
    logic [31:0] QA;
    logic [31:0] QB;

    typedef struct {
        string       tag;
        bit          port_b;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] model[8];
    int          n_checks;
    int          n_fails;

    reg_file_8x32 dut (
        .clk    (clk),
        .cr     (cr),
        .WE     (WE),
        .Di     (Di),
        .Addr_W (Addr_W),
        .Addr_A (Addr_A),
        .Addr_B (Addr_B),
        .QA     (QA),
        .QB     (QB)
    );

    // 40 ns clock period: rising edges at 20, 60, 100, ...
    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Pop every pending expectation and compare against the current outputs.
    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_eq(it.tag, it.port_b ? QB : QA, it.exp);
        end
    endtask

    // Drive both read addresses, record the model's expectation, sample 1 ns later.
    task automatic read_pair(input int a, input int b, input string ctx);
        sb_item_t it;
        Addr_A = 3'(a);
        Addr_B = 3'(b);
        it.tag = $sformatf("%s QA[%0d]", ctx, a); it.port_b = 1'b0; it.exp = model[a];
        sb_q.push_back(it);
        it.tag = $sformatf("%s QB[%0d]", ctx, b); it.port_b = 1'b1; it.exp = model[b];
        sb_q.push_back(it);
        #1;
        drain();
    endtask

    // One write across exactly one rising edge, launched from the falling edge.
    task automatic write_reg(input int a, input logic [31:0] d);
        @(negedge clk);
        WE     = 1'b1;
        Addr_W = 3'(a);
        Di     = d;
        @(negedge clk);
        WE     = 1'b0;
        model[a] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        cr = 1'b0; WE = 1'b0; Di = 32'h0; Addr_W = 3'd0; Addr_A = 3'd0; Addr_B = 3'd0;

        // Reset held: every register reads zero, before any clock edge.
        for (int i = 0; i < 8; i++) read_pair(i, 7 - i, "reset");

        @(negedge clk);
        cr = 1'b1;

        // Write sweep.
        for (int k = 0; k < 4; k++) begin
            write_reg(2 * k,     32'hAAAAAAA0 + 32'(2 * k));
            write_reg(2 * k + 1, 32'h55555551 + 32'(2 * k));
        end
        for (int i = 0; i < 8; i++) read_pair(i, i, "sweep");
        for (int i = 0; i < 8; i++) read_pair(i, 7 - i, "cross");

        // Dual port, then swapped addresses in the same cycle.
        @(negedge clk);
        read_pair(3, 6, "dual");
        read_pair(6, 3, "swap");

        // Write disabled over several edges.
        @(negedge clk);
        WE = 1'b0; Addr_W = 3'd5; Di = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        read_pair(5, 5, "we0");

        // Read during write: old value before the edge, new value after.
        @(negedge clk);
        Addr_W = 3'd1; WE = 1'b1; Di = 32'h12345678;
        read_pair(1, 1, "rdw_pre");
        @(posedge clk);
        model[1] = 32'h12345678;
        read_pair(1, 1, "rdw_post");
        @(negedge clk);
        WE = 1'b0;

        // WE pulse confined to the low phase: no edge, no write.
        @(negedge clk);
        #2;
        Addr_W = 3'd2; Di = 32'hFFFFFFFF; WE = 1'b1;
        #15;
        WE = 1'b0;
        repeat (2) @(negedge clk);
        read_pair(2, 2, "pulse");

        // Asynchronous reset mid-cycle: clears immediately without a clock edge.
        @(negedge clk);
        #5;
        cr = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        for (int i = 0; i < 8; i++) read_pair(i, 7 - i, "async_rst");

        // Writes are ignored while reset is asserted.
        WE = 1'b1; Addr_W = 3'd4; Di = 32'hCAFEF00D;
        @(posedge clk);
        read_pair(4, 4, "rst_wr");
        @(negedge clk);
        WE = 1'b0;
        cr = 1'b1;
        read_pair(4, 0, "rst_rel");

        // Normal writes resume after release.
        write_reg(4, 32'h0BADF00D);
        read_pair(4, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
